ordered_dither_stream: RTL and testbench
========================================

# ordered_dither_stream

Parametrised, stream-based ordered-dithering stage: quantises PIXELS pixels per beat from IN_BITS to OUT_BITS grey levels using a run-time selectable Bayer threshold matrix. It tracks screen position internally from start-of-line and start-of-frame flags. It sits between the pixel-processing pipeline and the EPD waveform lookup, and supersedes the fixed 4-pixel/4-bit dither with externally supplied position.

## Interface
- PIXELS, 4, pixels per beat (1..8)
- IN_BITS, 8, input bits per pixel
- OUT_BITS, 4, output bits per pixel; IN_BITS-OUT_BITS ≥ 1
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  0 = truncate, 1 = Bayer 4x4, 2 = Bayer 8x8, 3 = truncate
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  PIXELS*IN_BITS  pixel 0 in LSBs
- s_sol  in  1  beat is first of a line
- s_sof  in  1  beat is first of a frame; always asserted with s_sol
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts
- m_data  out  PIXELS*OUT_BITS  pixel 0 in LSBs

## Operation
- SH = IN_BITS-OUT_BITS; N = 4 or 8; M = Bayer value at [row][col], range 0..N²-1.
- Bayer 4x4 rows: {0,8,2,10},{12,4,14,6},{3,11,1,9},{15,7,13,5}. Bayer 8x8 is the standard recursive extension.
- Offset = (M << SH) >> log2(N²), range 0..2^SH-1. Truncate mode uses offset 0.
- Output = min((in + offset) >> SH, 2^OUT_BITS-1). The sum is computed at IN_BITS+1 width; saturation is mandatory.
- Position counters advance only on accepted input beats:
  - xbeat: 0 on an s_sol beat, otherwise +1.
  - y: 0 on an s_sof beat; +1 on s_sol beats without s_sof.
  - Counters wrap naturally at their width (16 bits).
- Lane i position: x = xbeat*PIXELS + i; col = x mod N, row = y mod N.
- mode is latched on each accepted s_sof beat and applies from that beat on. Mode changes mid-frame are ignored until the next frame.
- A beat with s_sol never asserted since reset is dithered with position x=xbeat and y=0.

## Timing
- Pipeline is two register stages: S1 registers the offset lookup, sum and position; S2 performs the shift/saturate into the output register.
- Latency is 2 cycles from accept to m_valid when m_ready is held high. Throughput is 1 beat/cycle.
- Global stall: advance = !m_valid || m_ready; s_ready = advance. s_ready is combinational from m_ready and m_valid.
- While stalled, m_data and m_valid hold stable and S1 holds. No beat is dropped or duplicated.
- Bubbles are not collapsed while stalled.
- Reset values: m_valid=0, m_data=0, S1 valid=0, xbeat=0, y=0, latched mode=1, frame counter=0.
- Reset mid-stream discards in-flight beats. s_ready returns to 1 in the cycle after rst deasserts.

## Configuration
- ORDERED_DITHER_TEMPORAL_EN defined: a log2(8)-bit frame counter f increments on each accepted s_sof beat, after that beat's lookup.
  - row = (y + f) mod N; col = (x + 2f) mod N.
  - This rotates the pattern every frame to reduce fixed-pattern ghosting.
- Not defined: f is absent and treated as 0. Behaviour is purely spatial.

## Structure
- Package ordered_dither_pkg holds:
  - mode encoding constants
  - Bayer 4x4 and 8x8 constant arrays (or lookup functions)
  - the offset-scaling function
- Sub-module dither_lane holds one pixel's add, shift and saturate logic, parametrised by IN_BITS/OUT_BITS, instantiated PIXELS times.
- The top level owns the counters, mode latch, stall control and pipeline registers.

## Test plan
- mode=0, IN=8, OUT=4, s_data pixels 0x00, 0x7F, 0xF0, 0xFF → m_data nibbles 0x0, 0x7, 0xF, 0xF two cycles after accept.
- mode=1, sof beat, all pixels 0x08 → lanes x=0..3, row 0 with offsets 0, 8, 2, 10 → outputs 0, 1, 0, 1. Next line, offsets 12, 4, 14, 6 → 1, 0, 1, 0.
- mode=1, all pixels 0xFF on every row → every output 0xF (saturation, no wrap to 0).
- mode=2, 64 uniform 0x80 pixels spanning 8 rows × 8 columns → all outputs 0x8 (offset < 16 never overflows the nibble).
- Random m_ready toggling over 1000 beats against a reference model → identical sequence, m_data stable whenever m_valid && !m_ready.
- mode switched 1→0 mid-frame → output stays Bayer until the next s_sof. With ORDERED_DITHER_TEMPORAL_EN, frame 1 row 0 lane 0 uses M[1][2]=14.

Source files
------------

// File: rtl/ordered_dither_pkg.sv
// Shared mode encoding, Bayer threshold lookups and offset scaling for the ordered dither stage.
package ordered_dither_pkg;

    localparam int POS_BITS = 16;

    typedef enum logic [1:0] {
        MODE_TRUNC     = 2'd0,
        MODE_BAYER4    = 2'd1,
        MODE_BAYER8    = 2'd2,
        MODE_TRUNC_ALT = 2'd3
    } mode_e;

    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6},
        '{4'd3,  4'd11, 4'd1,  4'd9},
        '{4'd15, 4'd7,  4'd13, 4'd5}
    };

    function automatic logic [3:0] bayer4(input logic [1:0] row, input logic [1:0] col);
        return BAYER4[row][col];
    endfunction

    // Recursive extension: 4*M4[r%4][c%4] + M2[r/4][c/4], where M2 = {{0,2},{3,1}}.
    function automatic logic [5:0] bayer8(input logic [2:0] row, input logic [2:0] col);
        logic [1:0] quad;
        quad = {row[2] ^ col[2], row[2]};
        return {bayer4(row[1:0], col[1:0]), quad};
    endfunction

    // Scales a threshold in 0..2^log2nn-1 onto 0..2^sh-1.
    function automatic int unsigned offset_scale(input int unsigned m, input int unsigned sh,
                                                 input int unsigned log2nn);
        return (m << sh) >> log2nn;
    endfunction

    function automatic int unsigned dither_offset(input mode_e md, input logic [2:0] row,
                                                  input logic [2:0] col, input int unsigned sh);
        int unsigned off;
        off = 0;
        case (md)
            MODE_BAYER4: off = offset_scale(32'(bayer4(row[1:0], col[1:0])), sh, 4);
            MODE_BAYER8: off = offset_scale(32'(bayer8(row, col)), sh, 6);
            default:     off = 0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/dither_lane.sv
// One pixel of the dither pipeline: registered sum (S1), then shift and saturate into the output (S2).
module dither_lane
    import ordered_dither_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [IN_BITS-1:0]  pix,
    input  logic [IN_BITS-1:0]  offset,
    output logic [OUT_BITS-1:0] q
);
    localparam int unsigned SH = IN_BITS - OUT_BITS;
    localparam logic [IN_BITS:0] LIMIT = (IN_BITS + 1)'((1 << OUT_BITS) - 1);

    logic [IN_BITS:0]    sum_q;
    logic [IN_BITS:0]    shifted;
    logic [OUT_BITS-1:0] sat;

    // The extra sum bit catches carry-out so bright pixels clamp instead of wrapping to black.
    assign shifted = sum_q >> SH;
    assign sat     = (shifted > LIMIT) ? '1 : shifted[OUT_BITS-1:0];

    // NOTE: state is updated with <= so every register samples pre-edge values, avoiding
    // simulation races and matching the flops synthesis builds; data registers are reset
    // too because the output must read zero after reset, not whatever was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            q     <= '0;
        end else if (en) begin
            sum_q <= {1'b0, pix} + {1'b0, offset};
            q     <= sat;
        end
    end

endmodule

// File: rtl/ordered_dither_stream.sv
// Ordered-dither stream stage: tracks screen position, selects a Bayer offset per lane and
// quantises through a two-stage stalled pipeline. Optional macro: ORDERED_DITHER_TEMPORAL_EN.
module ordered_dither_stream
    import ordered_dither_pkg::*;
#(
    parameter int PIXELS   = 4,
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [PIXELS*IN_BITS-1:0]  s_data,
    input  logic                       s_sol,
    input  logic                       s_sof,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [PIXELS*OUT_BITS-1:0] m_data
);
    localparam int unsigned SH = IN_BITS - OUT_BITS;

    logic                advance;
    logic                accept;
    logic                s1_valid;
    logic [POS_BITS-1:0] xbeat_q;
    logic [POS_BITS-1:0] y_q;
    logic [POS_BITS-1:0] beat_x;
    logic [POS_BITS-1:0] beat_y;
    mode_e               mode_q;
    mode_e               beat_mode;
    logic [2:0]          frame_f;

    // One global enable: the whole pipe moves together or holds together.
    assign advance = !m_valid || m_ready;
    assign s_ready = advance;
    assign accept  = s_valid && advance;

    // Position and mode of the beat being offered, before the counters absorb it.
    assign beat_x    = s_sol ? '0 : xbeat_q;
    assign beat_y    = s_sof ? '0 : (s_sol ? y_q + POS_BITS'(1) : y_q);
    assign beat_mode = s_sof ? mode_e'(mode) : mode_q;

`ifdef ORDERED_DITHER_TEMPORAL_EN
    logic [2:0] frame_q;

    // The s_sof beat itself still sees the previous frame's value.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else if (accept && s_sof) begin
            frame_q <= frame_q + 3'd1;
        end
    end

    assign frame_f = frame_q;
`else
    assign frame_f = 3'd0;
`endif

    for (genvar i = 0; i < PIXELS; i++) begin : g_lane
        logic [2:0]         row8;
        logic [2:0]         col8;
        logic [IN_BITS-1:0] offset;

        // Only the low three position bits matter, since N divides 8.
        assign row8   = beat_y[2:0] + frame_f;
        assign col8   = beat_x[2:0] * 3'(PIXELS) + 3'(i) + {frame_f[1:0], 1'b0};
        assign offset = IN_BITS'(dither_offset(beat_mode, row8, col8, SH));

        dither_lane #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (advance),
            .pix    (s_data[i*IN_BITS +: IN_BITS]),
            .offset (offset),
            .q      (m_data[i*OUT_BITS +: OUT_BITS])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            m_valid  <= 1'b0;
            xbeat_q  <= '0;
            y_q      <= '0;
            mode_q   <= MODE_BAYER4;
        end else begin
            if (advance) begin
                s1_valid <= s_valid;
                m_valid  <= s1_valid;
            end
            if (accept) begin
                xbeat_q <= beat_x + POS_BITS'(1);
                y_q     <= beat_y;
                if (s_sof) begin
                    mode_q <= beat_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_ordered_dither_stream.sv
// Self-checking bench for ordered_dither_stream: reference-model scoreboard plus directed cases.
module tb_ordered_dither_stream;

    localparam int PIXELS   = 4;
    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 4;
    localparam int SH       = IN_BITS - OUT_BITS;
    localparam int DW       = PIXELS * IN_BITS;
    localparam int QW       = PIXELS * OUT_BITS;

`ifdef ORDERED_DITHER_TEMPORAL_EN
    localparam logic [QW-1:0] EXP_ROW1     = 16'h1010;
    localparam logic [QW-1:0] EXP_MIDFRAME = 16'h0101;
    localparam logic [QW-1:0] EXP_FRAME1   = 16'h0001;
`else
    localparam logic [QW-1:0] EXP_ROW1     = 16'h0101;
    localparam logic [QW-1:0] EXP_MIDFRAME = 16'h1010;
    localparam logic [QW-1:0] EXP_FRAME1   = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'd1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_sol = 1'b0;
    logic          s_sof = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [QW-1:0] m_data;

    always #5 clk = ~clk;

    ordered_dither_stream #(
        .PIXELS   (PIXELS),
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sol   (s_sol),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [QW-1:0] sb[$];
    logic [15:0]   mx = '0;
    logic [15:0]   my = '0;
    logic [1:0]    mmode = 2'd1;
    logic [2:0]    mf = '0;
    bit            const_en = 1'b0;
    logic [QW-1:0] const_val = '0;
    bit            prev_stall = 1'b0;
    logic [QW-1:0] prev_data = '0;

    int B4[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    int B8[8][8] = '{
        '{ 0, 32,  8, 40,  2, 34, 10, 42},
        '{48, 16, 56, 24, 50, 18, 58, 26},
        '{12, 44,  4, 36, 14, 46,  6, 38},
        '{60, 28, 52, 20, 62, 30, 54, 22},
        '{ 3, 35, 11, 43,  1, 33,  9, 41},
        '{51, 19, 59, 27, 49, 17, 57, 25},
        '{15, 47,  7, 39, 13, 45,  5, 37},
        '{63, 31, 55, 23, 61, 29, 53, 21}
    };

    function automatic logic [QW-1:0] model_out(input logic [DW-1:0] d, input logic [15:0] bx,
                                                input logic [15:0] by, input logic [1:0] md,
                                                input logic [2:0] f);
        logic [QW-1:0] r;
        r = '0;
        for (int i = 0; i < PIXELS; i++) begin
            int x, row, col, off, pix, o;
            x   = int'(bx) * PIXELS + i;
            pix = int'(d[i*IN_BITS +: IN_BITS]);
            off = 0;
            if (md == 2'd1) begin
                row = (int'(by) + int'(f)) % 4;
                col = (x + 2 * int'(f)) % 4;
                off = (B4[row][col] << SH) / 16;
            end else if (md == 2'd2) begin
                row = (int'(by) + int'(f)) % 8;
                col = (x + 2 * int'(f)) % 8;
                off = (B8[row][col] << SH) / 64;
            end
            o = (pix + off) >> SH;
            if (o > (1 << OUT_BITS) - 1) o = (1 << OUT_BITS) - 1;
            r[i*OUT_BITS +: OUT_BITS] = OUT_BITS'(o);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rep(input logic [IN_BITS-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < PIXELS; i++) r[i*IN_BITS +: IN_BITS] = v;
        return r;
    endfunction

    task automatic model_reset();
        mx = '0; my = '0; mmode = 2'd1; mf = '0;
        sb.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input bit sol, input bit sof,
                                input logic [1:0] md);
        logic [15:0] bx, by;
        logic [1:0]  bm;
        bx = sol ? 16'd0 : mx;
        by = sof ? 16'd0 : (sol ? my + 16'd1 : my);
        bm = sof ? md : mmode;
        sb.push_back(model_out(d, bx, by, bm, mf));
        mx = bx + 16'd1;
        my = by;
        if (sof) begin
            mmode = md;
`ifdef ORDERED_DITHER_TEMPORAL_EN
            mf = mf + 3'd1;
`endif
        end
    endtask

    // Output monitor: scoreboard pops on each handshake and hold-stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    n_err++;
                    $display("FAIL stall_hold: m_valid=%b m_data=%h, required 1 and %h", m_valid, m_data, prev_data);
                end
            end
            if (m_valid && m_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: m_data=%h with empty scoreboard", m_data);
                end else begin
                    logic [QW-1:0] exp_d;
                    exp_d = sb.pop_front();
                    if (m_data !== exp_d) begin
                        n_err++;
                        $display("FAIL scoreboard: m_data=%h, required %h", m_data, exp_d);
                    end
                end
                if (const_en) begin
                    n_vec++;
                    if (m_data !== const_val) begin
                        n_err++;
                        $display("FAIL uniform_output: m_data=%h, required %h", m_data, const_val);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_sol = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit sol, input bit sof,
                             input logic [1:0] md, output int waited);
        s_valid = 1'b1; s_data = d; s_sol = sol; s_sof = sof; mode = md;
        waited = 0;
        @(negedge clk);
        while (!s_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!s_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: s_ready=%b after %0d cycles, required 1", s_ready, waited);
        end else begin
            model_accept(d, sol, sof, md);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_sol = 1'b0; s_sof = 1'b0;
    endtask

    task automatic wait_output(output logic [QW-1:0] d, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 20);
        d = m_data;
    endtask

    task automatic drain();
        int g;
        g = 0;
        m_ready = 1'b1;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec += 3;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h, required 0", m_data); end
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_truncate();
        logic [QW-1:0] d;
        int w, lat;
        send_beat(32'hFFF07F00, 1'b1, 1'b1, 2'd0, w);
        wait_output(d, lat);
        n_vec += 2;
        if (d !== 16'hFF70) begin n_err++; $display("FAIL truncate_m0: got %h, required ff70", d); end
        if (lat !== 2) begin n_err++; $display("FAIL latency: got %0d cycles, required 2", lat); end
        @(posedge clk); #1;
        send_beat(32'h801F100F, 1'b1, 1'b1, 2'd3, w);
        wait_output(d, lat);
        n_vec++;
        if (d !== 16'h8110) begin n_err++; $display("FAIL truncate_m3: got %h, required 8110", d); end
        @(posedge clk); #1;
    endtask

    task automatic test_bayer4();
        logic [QW-1:0] d;
        int w, lat;
        do_reset();
        send_beat(rep(8'h08), 1'b1, 1'b1, 2'd1, w);
        wait_output(d, lat);
        n_vec++;
        if (d !== 16'h1010) begin n_err++; $display("FAIL bayer4_row0: got %h, required 1010", d); end
        @(posedge clk); #1;
        send_beat(rep(8'h08), 1'b1, 1'b0, 2'd1, w);
        wait_output(d, lat);
        n_vec++;
        if (d !== EXP_ROW1) begin n_err++; $display("FAIL bayer4_row1: got %h, required %h", d, EXP_ROW1); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input logic [IN_BITS-1:0] v, input logic [1:0] md,
                                     input int rows, input logic [QW-1:0] expect_all);
        int w;
        const_en = 1'b1; const_val = expect_all;
        for (int r = 0; r < rows; r++) begin
            for (int b = 0; b < 8 / PIXELS; b++) begin
                send_beat(rep(v), b == 0, (b == 0) && (r == 0), md, w);
                n_vec++;
                if (w !== 0) begin n_err++; $display("FAIL throughput: waited %0d cycles, required 0", w); end
            end
        end
        drain();
        const_en = 1'b0;
    endtask

    task automatic test_mode_switch();
        logic [QW-1:0] d;
        int w, lat;
        do_reset();
        send_beat(rep(8'h08), 1'b1, 1'b1, 2'd1, w);
        drain();
        send_beat(rep(8'h08), 1'b0, 1'b0, 2'd0, w);
        wait_output(d, lat);
        n_vec++;
        if (d !== EXP_MIDFRAME) begin n_err++; $display("FAIL midframe_mode: got %h, required %h", d, EXP_MIDFRAME); end
        @(posedge clk); #1;
        send_beat(rep(8'h08), 1'b1, 1'b0, 2'd0, w);
        drain();
        send_beat(rep(8'h02), 1'b1, 1'b1, 2'd1, w);
        wait_output(d, lat);
        n_vec++;
        if (d !== EXP_FRAME1) begin n_err++; $display("FAIL frame1_sof: got %h, required %h", d, EXP_FRAME1); end
        @(posedge clk); #1;
        send_beat(rep(8'h08), 1'b1, 1'b1, 2'd0, w);
        send_beat(rep(8'h08), 1'b0, 1'b0, 2'd1, w);
        wait_output(d, lat);
        n_vec++;
        if (d !== 16'h0000) begin n_err++; $display("FAIL new_frame_trunc: got %h, required 0000", d); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_reset_midstream();
        logic [QW-1:0] d;
        int w, lat;
        m_ready = 1'b0;
        send_beat(rep(8'h40), 1'b1, 1'b1, 2'd2, w);
        send_beat(rep(8'h41), 1'b0, 1'b0, 2'd2, w);
        @(negedge clk);
        n_vec += 2;
        if (m_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b, required 1", m_valid); end
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b, required 0", s_ready); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                n_err++;
                $display("FAIL flush: m_valid=%b s_ready=%b, required 0 and 1", m_valid, s_ready);
            end
        end
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            send_beat(rep(8'h08), 1'b0, 1'b0, 2'd0, w);
            wait_output(d, lat);
            n_vec++;
            if (d !== 16'h1010) begin n_err++; $display("FAIL post_reset_nosol: got %h, required 1010", d); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_backpressure();
        int sent, guard;
        bit acc;
        logic [DW-1:0] d;
        sent = 0; guard = 0;
        while (sent < 1000 && guard < 20000) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (!s_valid && $urandom_range(0, 3) != 0) begin
                for (int i = 0; i < PIXELS; i++)
                    d[i*IN_BITS +: IN_BITS] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                s_valid = 1'b1;
                s_data  = d;
                s_sol   = ($urandom_range(0, 5) == 0);
                s_sof   = s_sol && ($urandom_range(0, 3) == 0);
                mode    = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc) model_accept(s_data, s_sol, s_sof, mode);
            @(posedge clk); #1;
            if (acc) begin
                s_valid = 1'b0; s_sol = 1'b0; s_sof = 1'b0;
                sent++;
            end
            guard++;
        end
        n_vec++;
        if (sent != 1000) begin n_err++; $display("FAIL random_progress: sent %0d beats, required 1000", sent); end
        drain();
    endtask

    initial begin
        test_reset();
        test_truncate();
        test_bayer4();
        test_back_to_back(8'hFF, 2'd1, 4, 16'hFFFF);
        test_back_to_back(8'h80, 2'd2, 8, 16'h8888);
        test_mode_switch();
        test_reset_midstream();
        test_random_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
